lsu_mem: RTL
============

# lsu_mem

Load/store unit for the MEM stage of the 16-bit-instruction pipeline. Decodes the instruction in MEM and issues word or byte accesses to the data memory over a request/grant/response handshake. Holds the pipeline with a stall while an access is outstanding, and delivers aligned, zero-extended load data to the writeback stage. It is the producer of the load result that writeback selects for the destination register on LDR-class instructions.

## Interface
Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `i_valid` input 1: `i_ir_mem` holds a real instruction; 0 means bubble.
- `i_ir_mem` input 16: instruction currently in MEM.
- `i_addr` input 32: effective address from EX (base+offset, or PC for literal).
- `i_wdata` input 32: store data (Rd value).
- `o_mem_req` output 1: memory request.
- `o_mem_we` output 1: 1 = store.
- `o_mem_addr` output 32: word-aligned address (`[1:0]` = 0).
- `o_mem_be` output 4: byte enables.
- `o_mem_wdata` output 32: store data, byte-replicated for byte stores.
- `i_mem_gnt` input 1: request accepted this cycle.
- `i_mem_rvalid` input 1: read data valid.
- `i_mem_rdata` input 32: read data.
- `o_stall` output 1: freeze IF..MEM this cycle.
- `o_rdata_wb` output 32: load result for WB.
- `o_misalign` output 1: one-cycle pulse on an unaligned word access.

## Operation
- Decode uses `i_ir_mem[15:11]`:
  - 01100: STR word.
  - 01101: LDR word.
  - 01110: STRB.
  - 01111: LDRB.
  - 01001: LDR literal (word at `{i_addr[31:2],2'b00}`; never misaligned).
  - All other codes, or `i_valid`=0: no access.
- FSM states:
  - IDLE
    - Memory op decoded and word access with `i_addr[1:0]`≠0 → pulse `o_misalign`, issue no access, stay IDLE.
    - Memory op decoded otherwise → register req/we/addr/be/wdata, go to REQ.
  - REQ
    - `o_mem_req`=1 and memory outputs held stable until `i_mem_gnt`.
    - On gnt: store → DONE; load → WAIT.
    - `o_mem_req` drops the cycle after gnt.
  - WAIT
    - On `i_mem_rvalid`: capture the extracted data into `o_rdata_wb`, go to DONE.
    - `i_mem_rvalid` in any other state is ignored.
  - DONE
    - One cycle with `o_stall`=0; the pipeline advances at the end of this cycle.
    - Always returns to IDLE; never re-decodes the same instruction.
- `o_stall` = memory op decoded (not misaligned) and state≠DONE. It is combinational, and asserted in the IDLE detect cycle as well.
- Byte enables:
  - Word access: 4'b1111.
  - Byte access: one-hot at `i_addr[1:0]` (00→0001, 11→1000).
  - Byte store: `o_mem_wdata` = `{4{i_wdata[7:0]}}`.
- Load extraction:
  - Word load: `i_mem_rdata` unchanged.
  - LDRB: byte selected by the latched `addr[1:0]`, zero-extended to 32 bits.
- `o_rdata_wb` holds its value until the next load capture.
- Misaligned access: the instruction proceeds with no memory access and `o_rdata_wb` unchanged. Trap handling lives elsewhere.
- Reset, at any time including mid-access:
  - state=IDLE.
  - `o_mem_req`=0, `o_mem_we`=0, `o_mem_addr`=0, `o_mem_be`=0, `o_mem_wdata`=0.
  - `o_rdata_wb`=0, `o_misalign`=0, `o_stall`=0.
  - A late `i_mem_rvalid`/`i_mem_gnt` arriving after reset is ignored.

## Timing
- With zero-wait memory (gnt in the REQ cycle, rvalid the next cycle):
  - Load: IDLE(c0) → REQ(c1) → WAIT(c2) → DONE(c3).
    - `o_stall` is high c0–c2.
    - `o_rdata_wb` is valid from c3 and is read by WB in c4.
  - Store: IDLE(c0) → REQ(c1) → DONE(c2).
    - `o_stall` is high c0–c1.
- Each gnt wait cycle or rvalid wait cycle adds one stall cycle.
- gnt and rvalid are never accepted in the same cycle; rvalid must be seen in WAIT.
- Back-to-back memory ops: after DONE the next instruction is decoded in IDLE in the following cycle. This gives a minimum of 3 cycles per store and 4 per load.
- `o_misalign` is high for exactly the detect cycle. `o_stall`=0 in that cycle.

## Test plan
- LDR, `i_addr`=0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF.
  - `o_mem_addr`=0x100, be=1111.
  - Stall for 3 cycles.
  - `o_rdata_wb`=0xDEADBEEF in the DONE cycle.
- LDRB, `i_addr`=0x203, rdata=0x12345678 → be=1000, `o_mem_addr`=0x200, `o_rdata_wb`=0x00000012.
- STRB, `i_addr`=0x301, `i_wdata`=0xAB, gnt delayed 2 cycles.
  - be=0010, wdata=0xABABABAB.
  - req held with stable outputs for 3 cycles.
  - Stall for 4 cycles, then DONE.
- LDR, `i_addr`=0x102 → `o_misalign` pulse for 1 cycle, no `o_mem_req`, `o_stall`=0.
- LDR literal, `i_addr`=0x1006 → `o_mem_addr`=0x1004, no misalign.
  - A following ALU op (opcode 00011) produces no request.
- Reset asserted in WAIT; rvalid arrives after reset release.
  - All outputs go to 0 immediately.
  - State is IDLE.
  - `o_rdata_wb` stays 0.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Data-memory bus seen by the load/store unit: request/grant handshake
// on the way out, read-valid/read-data on the way back.
interface lsu_mem_if;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    // The load/store unit drives requests and consumes grants/responses
    modport master (
        output o_mem_req,
        output o_mem_we,
        output o_mem_addr,
        output o_mem_be,
        output o_mem_wdata,
        input  i_mem_gnt,
        input  i_mem_rvalid,
        input  i_mem_rdata
    );

    // The memory accepts requests and returns grants/responses
    modport slave (
        input  o_mem_req,
        input  o_mem_we,
        input  o_mem_addr,
        input  o_mem_be,
        input  o_mem_wdata,
        output i_mem_gnt,
        output i_mem_rvalid,
        output i_mem_rdata
    );
endinterface

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit. Decodes the instruction in MEM, issues one
// word or byte access over the request/grant/response bus, stalls the
// pipeline while the access is outstanding, and hands aligned,
// zero-extended load data to writeback.
module lsu_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [15:0] i_ir_mem,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    lsu_mem_if.master   mem,
    output logic        o_stall,
    output logic [31:0] o_rdata_wb,
    output logic        o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        isLoad_q, isLoad_d;
    logic        byteLoad_q, byteLoad_d;
    logic [1:0]  byteSel_q, byteSel_d;
    logic [31:0] rdata_q, rdata_d;

    logic        memOp;
    logic        isLoad;
    logic        isByte;
    logic        checkAlign;
    logic        misaligned;
    logic        stallRaw;
    logic        misalignRaw;
    logic [7:0]  selByte;
    logic [31:0] loadData;
    logic [4:0]  opcode;
    logic        unusedIr;

    assign opcode   = i_ir_mem[15:11];
    assign unusedIr = ^i_ir_mem[10:0];

    // Classify the instruction in MEM; literal loads skip the alignment check
    always_comb begin
        memOp      = 1'b0;
        isLoad     = 1'b0;
        isByte     = 1'b0;
        checkAlign = 1'b0;
        if (i_valid) begin
            case (opcode)
                5'b01100: begin memOp = 1'b1; checkAlign = 1'b1; end
                5'b01101: begin memOp = 1'b1; checkAlign = 1'b1; isLoad = 1'b1; end
                5'b01110: begin memOp = 1'b1; isByte = 1'b1; end
                5'b01111: begin memOp = 1'b1; isByte = 1'b1; isLoad = 1'b1; end
                5'b01001: begin memOp = 1'b1; isLoad = 1'b1; end
                default:  begin memOp = 1'b0; end
            endcase
        end
    end

    assign misaligned = memOp && checkAlign && (i_addr[1:0] != 2'b00);

    // Pick the addressed byte lane of the returning read data
    always_comb begin
        case (byteSel_q)
            2'd0:    selByte = mem.i_mem_rdata[7:0];
            2'd1:    selByte = mem.i_mem_rdata[15:8];
            2'd2:    selByte = mem.i_mem_rdata[23:16];
            default: selByte = mem.i_mem_rdata[31:24];
        endcase
        loadData = byteLoad_q ? {24'h0, selByte} : mem.i_mem_rdata;
    end

    // Next-state, bus register updates and stall/misalign generation
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        isLoad_d    = isLoad_q;
        byteLoad_d  = byteLoad_q;
        byteSel_d   = byteSel_q;
        rdata_d     = rdata_q;
        stallRaw    = 1'b0;
        misalignRaw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memOp) begin
                    if (misaligned) begin
                        misalignRaw = 1'b1;
                    end else begin
                        stallRaw   = 1'b1;
                        req_d      = 1'b1;
                        we_d       = !isLoad;
                        addr_d     = {i_addr[31:2], 2'b00};
                        be_d       = isByte ? (4'b0001 << i_addr[1:0]) : 4'b1111;
                        wdata_d    = isByte ? {4{i_wdata[7:0]}} : i_wdata;
                        isLoad_d   = isLoad;
                        byteLoad_d = isByte && isLoad;
                        byteSel_d  = i_addr[1:0];
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stallRaw = 1'b1;
                if (mem.i_mem_gnt) begin
                    req_d   = 1'b0;
                    state_d = isLoad_q ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                stallRaw = 1'b1;
                if (mem.i_mem_rvalid) begin
                    rdata_d = loadData;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset drops any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus-side and writeback registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            isLoad_q   <= 1'b0;
            byteLoad_q <= 1'b0;
            byteSel_q  <= 2'b00;
            rdata_q    <= 32'h0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            isLoad_q   <= isLoad_d;
            byteLoad_q <= byteLoad_d;
            byteSel_q  <= byteSel_d;
            rdata_q    <= rdata_d;
        end
    end

    // Combinational outputs are forced low while reset is held
    assign o_stall         = stallRaw && rst;
    assign o_misalign      = misalignRaw && rst;
    assign o_rdata_wb      = rdata_q;
    assign mem.o_mem_req   = req_q;
    assign mem.o_mem_we    = we_q;
    assign mem.o_mem_addr  = addr_q;
    assign mem.o_mem_be    = be_q;
    assign mem.o_mem_wdata = wdata_q;

endmodule
